// File: rtl/lcd_rd_if.sv
// Bus bundle between the LCD read controller and its surroundings.
// The slave modport is the controller side; the master modport is the requester/LCD side.
interface lcd_rd_if;
    logic       req_i;
    logic       req_rs_i;
    logic       req_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       busy_flag_o;
    logic [6:0] addr_o;
    logic       rs_o;
    logic       rw_o;
    logic       en_o;
    logic [7:0] lcd_data_i;
    logic       bus_release_o;

    modport slave (
        input  req_i, req_rs_i, lcd_data_i,
        output req_ready_o, rd_data_o, rd_valid_o, busy_flag_o, addr_o,
               rs_o, rw_o, en_o, bus_release_o
    );

    modport master (
        output req_i, req_rs_i, lcd_data_i,
        input  req_ready_o, rd_data_o, rd_valid_o, busy_flag_o, addr_o,
               rs_o, rw_o, en_o, bus_release_o
    );
endinterface

// File: rtl/lcd_rd.sv
// HD44780 read-side controller: one timed rs/rw/en read cycle per request.
// Optional busy-flag polling is enabled with the LCD_RD_BF_POLL_EN macro.
module lcd_rd #(
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 5,
    parameter int HOLD_CYC    = 3,
    parameter int POLL_MAX    = 255
) (
    input  logic    clk_i,
    input  logic    rst_i,
    lcd_rd_if.slave bus
);

    // Zero-length phases are stretched to one cycle; counters run down to zero.
    localparam int S_EFF = (SETUP_CYC   < 1) ? 1 : SETUP_CYC;
    localparam int H_EFF = (EN_HIGH_CYC < 1) ? 1 : EN_HIGH_CYC;
    localparam int L_EFF = (HOLD_CYC    < 1) ? 1 : HOLD_CYC;
    localparam logic [7:0] S_LOAD   = 8'(S_EFF - 1);
    localparam logic [7:0] H_LOAD   = 8'(H_EFF - 1);
    localparam logic [7:0] L_LOAD   = 8'(L_EFF - 1);
    localparam logic [7:0] POLL_LIM = 8'((POLL_MAX < 1) ? 1 : POLL_MAX);

    typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cap_q;
    logic       rs_q, rs_d;
    logic       loop_q, loop_d;
    logic       cap_en, publish, retry, bus_win;

`ifdef LCD_RD_BF_POLL_EN
    logic [7:0] attempt_q, attempt_d;
`else
    logic       unused_poll;
    assign unused_poll = ^POLL_LIM;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        loop_d  = loop_q;
        cap_en  = 1'b0;
        publish = 1'b0;
`ifdef LCD_RD_BF_POLL_EN
        attempt_d = attempt_q;
        retry     = !rs_q && cap_q[7] && (attempt_q < POLL_LIM);
`else
        retry     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    state_d = SETUP;
                    cnt_d   = S_LOAD;
                    rs_d    = bus.req_rs_i;
                    loop_d  = 1'b0;
`ifdef LCD_RD_BF_POLL_EN
                    attempt_d = 8'd1;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = EN_HI;
                    cnt_d   = H_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            EN_HI: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = L_LOAD;
                    cap_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                    loop_d  = retry;
                    publish = !retry;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                // A pending busy retry re-runs the bus cycle without returning to IDLE.
                if (loop_q) begin
                    state_d = SETUP;
                    cnt_d   = S_LOAD;
`ifdef LCD_RD_BF_POLL_EN
                    attempt_d = attempt_q + 8'd1;
`endif
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        bus_win = (state_d == SETUP) || (state_d == EN_HI) || (state_d == HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            cap_q   <= 8'd0;
            rs_q    <= 1'b0;
            loop_q  <= 1'b0;
`ifdef LCD_RD_BF_POLL_EN
            attempt_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            loop_q  <= loop_d;
            if (cap_en) begin
                cap_q <= bus.lcd_data_i;
            end
`ifdef LCD_RD_BF_POLL_EN
            attempt_q <= attempt_d;
`endif
        end
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.req_ready_o   <= 1'b1;
            bus.en_o          <= 1'b0;
            bus.rw_o          <= 1'b0;
            bus.rs_o          <= 1'b0;
            bus.bus_release_o <= 1'b0;
            bus.rd_valid_o    <= 1'b0;
            bus.rd_data_o     <= 8'd0;
            bus.busy_flag_o   <= 1'b0;
            bus.addr_o        <= 7'd0;
        end else begin
            bus.req_ready_o   <= (state_d == IDLE);
            bus.en_o          <= (state_d == EN_HI);
            bus.rw_o          <= bus_win;
            bus.rs_o          <= bus_win & rs_d;
            bus.bus_release_o <= (state_d != IDLE);
            bus.rd_valid_o    <= publish;
            if (publish) begin
                bus.rd_data_o <= cap_q;
                if (!rs_q) begin
                    bus.busy_flag_o <= cap_q[7];
                    bus.addr_o      <= cap_q[6:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_rd.sv
// Self-checking bench for lcd_rd: table vectors, randomized reads against a
// transaction-level model, plus back-to-back, reset, short-timing and polling sequences.
module tb_lcd_rd;

    localparam int S = 2;
    localparam int H = 5;
    localparam int L = 3;
    localparam int T = S + H + L;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mdl_rd;
    logic       mdl_bf;
    logic [6:0] mdl_addr;

    lcd_rd_if bus ();
    lcd_rd_if bus2 ();

    lcd_rd dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    lcd_rd #(.SETUP_CYC(0), .EN_HIGH_CYC(0), .HOLD_CYC(0)) dut_short (
        .clk_i(clk), .rst_i(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       rs;
        logic [7:0] cap;
        logic [7:0] exp_rd;
        logic       exp_bf;
        logic [6:0] exp_addr;
    } vec_t;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full read starting mid-cycle 0 with the DUT idle; checks the pin timeline.
    task automatic apply_stimulus(input logic rs, input logic [7:0] cap);
        logic [63:0] en_a, rw_a, rs_a, v_a, rdy_a, rel_a;
        logic [63:0] en_e, rw_e, rs_e, v_e, rdy_e, rel_e;
        en_a = '0; rw_a = '0; rs_a = '0; v_a = '0; rdy_a = '0; rel_a = '0;
        en_e = '0; rw_e = '0; rs_e = '0; v_e = '0; rdy_e = '0; rel_e = '0;
        for (int c = 0; c <= T + 2; c++) begin
            if (c > 0) @(negedge clk);
            en_a[c]  = bus.en_o;
            rw_a[c]  = bus.rw_o;
            rs_a[c]  = bus.rs_o;
            v_a[c]   = bus.rd_valid_o;
            rdy_a[c] = bus.req_ready_o;
            rel_a[c] = bus.bus_release_o;
            en_e[c]  = (c >= S + 1) && (c <= S + H);
            rw_e[c]  = (c >= 1) && (c <= T);
            rs_e[c]  = rw_e[c] && rs;
            v_e[c]   = (c == T + 1);
            rdy_e[c] = (c == 0) || (c == T + 2);
            rel_e[c] = (c >= 1) && (c <= T + 1);
            if (c == 0) begin
                bus.req_i    = 1'b1;
                bus.req_rs_i = rs;
            end else if (c <= T + 1) begin
                bus.req_i    = 1'($urandom);
                bus.req_rs_i = 1'($urandom);
            end else begin
                bus.req_i    = 1'b0;
            end
            bus.lcd_data_i = (c == S + H) ? cap : 8'($urandom);
        end
        check_output("en_timeline", en_a, en_e);
        check_output("rw_timeline", rw_a, rw_e);
        check_output("rs_timeline", rs_a, rs_e);
        check_output("valid_timeline", v_a, v_e);
        check_output("ready_timeline", rdy_a, rdy_e);
        check_output("release_timeline", rel_a, rel_e);
        mdl_rd = cap;
        if (!rs) begin
            mdl_bf   = cap[7];
            mdl_addr = cap[6:0];
        end
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_rd_data"}, 64'(bus.rd_data_o), 64'(mdl_rd));
        check_output({tag, "_busy_flag"}, 64'(bus.busy_flag_o), 64'(mdl_bf));
        check_output({tag, "_addr"}, 64'(bus.addr_o), 64'(mdl_addr));
    endtask

    initial begin
        vec_t tbl[6];
        logic [63:0] rdy_a, rdy_e, en_a, en_e, v_a, v_e, rw_a, rw_e;
        int vcount, pulses, done_c;
        logic prev_en, rs_r;
        logic [7:0] cap_r;

        tbl[0] = '{1'b0, 8'h25, 8'h25, 1'b0, 7'h25};
        tbl[1] = '{1'b1, 8'hC1, 8'hC1, 1'b0, 7'h25};
        tbl[2] = '{1'b0, 8'h7F, 8'h7F, 1'b0, 7'h7F};
        tbl[3] = '{1'b1, 8'h80, 8'h80, 1'b0, 7'h7F};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 7'h00};
        tbl[5] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 7'h00};

        bus.req_i = 1'b0; bus.req_rs_i = 1'b0; bus.lcd_data_i = 8'h00;
        bus2.req_i = 1'b0; bus2.req_rs_i = 1'b0; bus2.lcd_data_i = 8'h00;
        mdl_rd = 8'h00; mdl_bf = 1'b0; mdl_addr = 7'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset_ready", 64'(bus.req_ready_o), 64'd1);
        check_output("reset_pins", 64'({bus.en_o, bus.rw_o, bus.rs_o, bus.bus_release_o, bus.rd_valid_o}), 64'd0);
        check_output("reset_data", 64'({bus.rd_data_o, bus.busy_flag_o, bus.addr_o}), 64'd0);
        rst = 1'b0;

        // Table-driven reads
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(tbl[i].rs, tbl[i].cap);
            check_output($sformatf("tbl%0d_rd_data", i), 64'(bus.rd_data_o), 64'(tbl[i].exp_rd));
            check_output($sformatf("tbl%0d_busy_flag", i), 64'(bus.busy_flag_o), 64'(tbl[i].exp_bf));
            check_output($sformatf("tbl%0d_addr", i), 64'(bus.addr_o), 64'(tbl[i].exp_addr));
        end

`ifdef LCD_RD_BF_POLL_EN
        // Busy for three captures, then ready: one valid after four bus cycles
        bus.req_i = 1'b1; bus.req_rs_i = 1'b0; bus.lcd_data_i = 8'h80;
        vcount = 0; pulses = 0; prev_en = 1'b0; done_c = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            bus.req_i = 1'b0;
            if (bus.en_o && !prev_en) pulses++;
            prev_en = bus.en_o;
            if (bus.rd_valid_o) begin
                vcount++;
                if (done_c < 0) done_c = c;
            end
            bus.lcd_data_i = (pulses <= 3) ? 8'h80 : 8'h10;
            if (done_c >= 0 && c >= done_c + 2) break;
        end
        check_output("poll_valid_count", 64'(vcount), 64'd1);
        check_output("poll_valid_cycle", 64'(done_c), 64'(4 * (T + 1)));
        check_output("poll_en_pulses", 64'(pulses), 64'd4);
        mdl_rd = 8'h10; mdl_bf = 1'b0; mdl_addr = 7'h10;
        check_model("poll");
`else
        // Busy flag set: still exactly one bus cycle and one valid
        apply_stimulus(1'b0, 8'hA7);
        check_output("bf_rd_data", 64'(bus.rd_data_o), 64'h0A7);
        check_output("bf_busy_flag", 64'(bus.busy_flag_o), 64'd1);
        check_output("bf_addr", 64'(bus.addr_o), 64'h27);
`endif

        // Randomized reads against the transaction model
        for (int i = 0; i < 20; i++) begin
            rs_r  = 1'($urandom);
            cap_r = 8'($urandom);
`ifdef LCD_RD_BF_POLL_EN
            if (!rs_r) cap_r[7] = 1'b0;
`endif
            apply_stimulus(rs_r, cap_r);
            check_model($sformatf("rand%0d", i));
        end

        // req held high: accepts every T+2 cycles
        bus.req_i = 1'b1; bus.req_rs_i = 1'b1; bus.lcd_data_i = 8'h5A;
        rdy_a = '0; rdy_e = '0; vcount = 0;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) @(negedge clk);
            rdy_a[c] = bus.req_ready_o;
            rdy_e[c] = (c % (T + 2)) == 0;
            if (bus.rd_valid_o) vcount++;
        end
        bus.req_i = 1'b0;
        check_output("b2b_ready_pattern", rdy_a, rdy_e);
        check_output("b2b_valid_count", 64'(vcount), 64'd2);
        repeat (8) @(negedge clk);
        mdl_rd = 8'h5A;
        check_output("b2b_ready_after", 64'(bus.req_ready_o), 64'd1);
        check_model("b2b");

        // Zero-cycle parameters behave as 1/1/1
        en_a = '0; en_e = '0; v_a = '0; v_e = '0; rdy_a = '0; rdy_e = '0; rw_a = '0; rw_e = '0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            en_a[c] = bus2.en_o;       en_e[c] = (c == 2);
            rw_a[c] = bus2.rw_o;       rw_e[c] = (c >= 1) && (c <= 3);
            v_a[c] = bus2.rd_valid_o;  v_e[c] = (c == 4);
            rdy_a[c] = bus2.req_ready_o; rdy_e[c] = (c == 0) || (c == 5);
            bus2.req_i = (c == 0);
            bus2.req_rs_i = 1'b1;
            bus2.lcd_data_i = (c == 2) ? 8'h9C : 8'($urandom);
        end
        check_output("short_en", en_a, en_e);
        check_output("short_rw", rw_a, rw_e);
        check_output("short_valid", v_a, v_e);
        check_output("short_ready", rdy_a, rdy_e);
        check_output("short_rd_data", 64'(bus2.rd_data_o), 64'h9C);

        // Reset during EN_HI
        vcount = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.rd_valid_o) vcount++;
            bus.req_i = (c == 0);
            bus.req_rs_i = 1'b0;
            bus.lcd_data_i = 8'($urandom);
        end
        check_output("rst_en_before", 64'(bus.en_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_pins", 64'({bus.en_o, bus.rw_o, bus.rs_o, bus.bus_release_o, bus.rd_valid_o}), 64'd0);
        check_output("rst_ready", 64'(bus.req_ready_o), 64'd1);
        check_output("rst_data", 64'({bus.rd_data_o, bus.busy_flag_o, bus.addr_o}), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.rd_valid_o) vcount++;
        end
        check_output("rst_no_valid", 64'(vcount), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
